seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative signed divider; the inverse of the 17x17 DSP multiplier path.
//  Takes a 2*DSIZE-bit dividend (e.g. a product p) and a DSIZE-bit divisor, and
//  returns a DSIZE-bit quotient and remainder using truncating division (same
//  results as Verilog / and %).
//  Used in the voice datapath for gain normalisation and un-scaling of MAC results.
//  One restoring-division step per clock, with a start/valid handshake.
// PARAMETERS
//  DSIZE  17  divisor/quotient/remainder width, two's complement (range 4..32)
//  NSIZE  2*DSIZE  dividend width (derived; do not override)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request; sampled only when in_ready=1
//  dividend   in   NSIZE  signed dividend, captured on accepting edge
//  divisor    in   DSIZE  signed divisor, captured on accepting edge
//  in_ready   out  1      =~busy; high when a start will be accepted
//  busy       out  1      operation in progress
//  out_valid  out  1      one-cycle pulse; q/r/ovf/dz valid and then held
//  q          out  DSIZE  signed quotient (saturated on ovf/dz)
//  r          out  DSIZE  signed remainder, sign follows dividend
//  ovf        out  1      quotient out of DSIZE-bit signed range
//  dz         out  1      divisor was zero
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, out_valid, q, r, ovf, dz all 0.
//   Asserting reset mid-operation aborts the operation; no out_valid is issued.
//  FSM IDLE->CALC->FIX->IDLE:
//   IDLE: start=1 at edge E0 latches |dividend| (NSIZE bits unsigned),
//    |divisor| (DSIZE bits unsigned), result sign (sn^sd), dividend sign, dz, and a
//    pre-overflow flag (|N|[NSIZE-1:DSIZE] >= |D|). busy=1, step cnt=DSIZE-1.
//   CALC: one restoring step per edge: shift the partial remainder left by 1,
//    bring in the next dividend bit, trial-subtract |D|, set quotient bit.
//    After DSIZE edges (E1..E_DSIZE) go to FIX.
//   FIX (edge E_DSIZE+1): apply signs, saturate, register q/r/ovf/dz,
//    out_valid=1, busy=0, go to IDLE.
//  Latency: out_valid is high in the cycle after edge E0+DSIZE+1 (18 clocks for
//   DSIZE=17). Throughput: 1 op per DSIZE+2 clocks.
//  Handshake: start while busy is ignored (not queued). start during the out_valid
//   cycle is accepted (busy=0 there). Inputs need only be stable at E0.
//  Arithmetic: qm = |N|/|D| (DSIZE-bit unsigned); rm = |N|%|D|.
//   q = result negative ? -qm : qm.   r = dividend negative ? -rm : rm.
//  Saturation: ovf=1 if pre-overflow, or qm>2^(DSIZE-1)-1 with positive result,
//   or qm>2^(DSIZE-1) with negative result. On ovf: q=MAXP (0x0FFFF) if result
//   positive, else MINN (0x10000); r=0.
//   qm==2^(DSIZE-1) with negative result is legal: q=MINN, ovf=0.
//  Divide by zero: dz=1, ovf=0, r=0; q=MAXP if dividend>=0, else MINN.
//   Latency is unchanged.
//  Extremes: dividend=-2^(NSIZE-1) and divisor=-2^(DSIZE-1) need no extra width;
//   magnitudes are held unsigned.
//  Outputs hold their last result until the next FIX edge or reset.
// TESTING (DSIZE=17)
//  1. Closed loop with the multiplier: random signed a,b (b!=0), dividend=a*b,
//     divisor=b -> q==a, r==0, ovf=0, out_valid exactly 18 clocks after start.
//     Directed case: -9592065/777 -> q=-12345.
//  2. Truncation signs: 100/-7 -> q=-14, r=2; -100/7 -> q=-14, r=-2;
//     -100/-7 -> q=14, r=-2.
//  3. Divide by zero: 5/0 -> q=0x0FFFF, r=0, dz=1; -5/0 -> q=0x10000, dz=1.
//  4. Range edges: 65536/1 -> q=0x0FFFF, ovf=1, r=0; -65536/1 -> q=0x10000,
//     ovf=0; 2^33-1 / 1 -> pre-overflow path, ovf=1, q=0x0FFFF.
//  5. Handshake: start pulsed on cycles 3 and 10 after an accepted start ->
//     both ignored, only one out_valid. start held high -> back-to-back ops
//     every 19 clocks, each accepted in its out_valid cycle.
//  6. Reset: rst_n=0 for 1 cycle at step 8 of CALC -> all outputs 0
//     immediately; no out_valid; a fresh start afterwards returns a correct result.

Source files
------------

// File: rtl/seq_divider.sv
// +-----------------------------------------------------------------------------+
// | seq_divider: iterative signed restoring divider, 2*DSIZE / DSIZE -> DSIZE   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module seq_divider #(
  parameter  int DSIZE = 17,
  localparam int NSIZE = 2 * DSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NSIZE-1:0] dividend,
  input  logic [DSIZE-1:0] divisor,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [DSIZE-1:0] q,
  output logic [DSIZE-1:0] r,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = $clog2(DSIZE);
  localparam logic [DSIZE-1:0] c_maxp = {1'b0, {(DSIZE-1){1'b1}}};
  localparam logic [DSIZE-1:0] c_minn = {1'b1, {(DSIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [DSIZE-1:0] r_absd;
  logic [DSIZE-1:0] r_rem;
  logic [DSIZE-1:0] r_lo;
  logic             r_neg;
  logic             r_nsign;
  logic             r_dz;
  logic             r_pre;

  logic [NSIZE-1:0] w_abs_n;
  logic [DSIZE-1:0] w_abs_d;
  logic [DSIZE:0]   w_shift;
  logic [DSIZE:0]   w_trial;
  logic             w_borrow;
  logic             w_ovf;

  // Magnitudes are unsigned, so the most negative operands need no extra bit.
  assign w_abs_n  = dividend[NSIZE-1] ? -dividend : dividend;
  assign w_abs_d  = divisor[DSIZE-1]  ? -divisor  : divisor;

  assign w_shift  = {r_rem, r_lo[DSIZE-1]};
  assign w_trial  = w_shift - {1'b0, r_absd};
  assign w_borrow = w_trial[DSIZE];

  // The magnitude range of a negative quotient reaches one step further.
  assign w_ovf    = r_pre | (~r_neg & (r_lo > c_maxp)) | (r_neg & (r_lo > c_minn));

  assign in_ready = ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_absd    <= '0;
      r_rem     <= '0;
      r_lo      <= '0;
      r_neg     <= 1'b0;
      r_nsign   <= 1'b0;
      r_dz      <= 1'b0;
      r_pre     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_absd    <= w_abs_d;
            r_rem     <= w_abs_n[NSIZE-1:DSIZE];
            r_lo      <= w_abs_n[DSIZE-1:0];
            r_neg     <= dividend[NSIZE-1] ^ divisor[DSIZE-1];
            r_nsign   <= dividend[NSIZE-1];
            r_dz      <= (divisor == '0);
            r_pre     <= (w_abs_n[NSIZE-1:DSIZE] >= w_abs_d);
            r_cnt     <= CW'(DSIZE - 1);
            busy      <= 1'b1;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          // Quotient bits shift in from the right as dividend bits leave on the left.
          r_rem <= w_borrow ? w_shift[DSIZE-1:0] : w_trial[DSIZE-1:0];
          r_lo  <= {r_lo[DSIZE-2:0], ~w_borrow};
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (r_dz) begin
            q   <= r_nsign ? c_minn : c_maxp;
            r   <= '0;
            ovf <= 1'b0;
            dz  <= 1'b1;
          end else if (w_ovf) begin
            q   <= r_neg ? c_minn : c_maxp;
            r   <= '0;
            ovf <= 1'b1;
            dz  <= 1'b0;
          end else begin
            q   <= r_neg ? -r_lo : r_lo;
            r   <= r_nsign ? -r_rem : r_rem;
            ovf <= 1'b0;
            dz  <= 1'b0;
          end
          out_valid <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +-----------------------------------------------------------------------------+
// | tb_seq_divider: scoreboard bench for seq_divider at DSIZE=17                |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [33:0] dividend;
  logic [16:0] divisor;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [16:0] q;
  logic [16:0] r;
  logic        ovf;
  logic        dz;

  typedef struct {
    logic [16:0] q;
    logic [16:0] r;
    logic        ovf;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   n_valid = 0;
  int   cyc     = 0;

  seq_divider #(.DSIZE(17)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .q         (q),
    .r         (r),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: full-width truncating division, then range saturation.
  function automatic exp_t model(longint n, longint d, int acc);
    exp_t   e;
    longint qf;
    longint rf;
    e.acc = acc;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    e.r   = '0;
    e.q   = '0;
    if (d == 0) begin
      e.dz = 1'b1;
      e.q  = (n < 0) ? 17'h10000 : 17'h0FFFF;
    end else begin
      qf = n / d;
      rf = n % d;
      if (qf > 65535) begin
        e.ovf = 1'b1;
        e.q   = 17'h0FFFF;
      end else if (qf < -65536) begin
        e.ovf = 1'b1;
        e.q   = 17'h10000;
      end else begin
        e.q = qf[16:0];
        e.r = rf[16:0];
      end
    end
    return e;
  endfunction

  // Scoreboard: pop and compare on each result, then push on each accepted start.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        n_valid++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 with q=%h r=%h, required no result pending", q, r);
        end else begin
          e = sb.pop_front();
          if ({q, r, ovf, dz} !== {e.q, e.r, e.ovf, e.dz}) begin
            errors++;
            $display("FAIL result: got q=%h r=%h ovf=%b dz=%b, required q=%h r=%h ovf=%b dz=%b",
                     q, r, ovf, dz, e.q, e.r, e.ovf, e.dz);
          end
          checks++;
          if (cyc - e.acc != 18) begin
            errors++;
            $display("FAIL latency: got %0d clocks, required 18", cyc - e.acc);
          end
        end
      end
      if (start === 1'b1 && in_ready === 1'b1)
        sb.push_back(model(longint'($signed(dividend)), longint'($signed(divisor)), cyc + 1));
    end
  end

  task automatic issue(longint n, longint d);
    @(posedge clk);
    #1;
    dividend = n[33:0];
    divisor  = d[16:0];
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(int maxc);
    for (int i = 0; i < maxc && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, out_valid, ovf, dz, q, r} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b vld=%b ovf=%b dz=%b q=%h r=%h, required all 0",
               busy, out_valid, ovf, dz, q, r);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_closed_loop;
    int a;
    int b;
    int v0;
    v0 = n_valid;
    issue(-9592065, 777);
    drain(40);
    for (int k = 0; k < 20; k++) begin
      a = int'($urandom_range(0, 131071)) - 65536;
      do b = int'($urandom_range(0, 131071)) - 65536; while (b == 0);
      issue(longint'(a) * longint'(b), longint'(b));
      drain(40);
    end
    checks++;
    if (sb.size() != 0 || n_valid - v0 != 21) begin
      errors++;
      $display("FAIL closed_loop_count: got %0d results with %0d pending, required 21 and 0",
               n_valid - v0, sb.size());
    end
  endtask

  task automatic test_signs;
    longint ns[4] = '{100, 100, -100, -100};
    longint ds[4] = '{-7, 7, 7, -7};
    for (int k = 0; k < 4; k++) begin
      issue(ns[k], ds[k]);
      drain(40);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL signs_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_div_zero;
    longint ns[3] = '{5, -5, 0};
    for (int k = 0; k < 3; k++) begin
      issue(ns[k], 0);
      drain(40);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL dz_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_range;
    longint ns[7] = '{65536, -65536, 64'h1_FFFF_FFFF, -(64'sd1 <<< 33), 65535, 131072, -(64'sd1 <<< 33)};
    longint ds[7] = '{1, 1, 1, -65536, 1, -2, 65535};
    for (int k = 0; k < 7; k++) begin
      issue(ns[k], ds[k]);
      drain(40);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL range_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_handshake;
    int v0;
    v0 = n_valid;
    issue(50000, 9);
    repeat (2) @(posedge clk);
    #1;
    dividend = 34'd777;
    divisor  = 17'd2;
    start    = 1'b1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_busy: got busy=%b in_ready=%b, required 1/0", busy, in_ready);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    dividend = 34'd12345;
    divisor  = 17'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain(40);
    repeat (25) @(posedge clk);
    checks++;
    if (n_valid - v0 != 1) begin
      errors++;
      $display("FAIL hs_single_valid: got %0d results, required 1", n_valid - v0);
    end
  endtask

  task automatic test_back_to_back;
    int t[3];
    int k;
    k = 0;
    @(posedge clk);
    #1;
    dividend = 34'd1000;
    divisor  = 17'h1FFFD;
    start    = 1'b1;
    for (int i = 0; i < 100 && k < 3; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        t[k] = cyc;
        k++;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    drain(40);
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 3", k);
    end else begin
      checks++;
      if (t[1] - t[0] != 19 || t[2] - t[1] != 19) begin
        errors++;
        $display("FAIL b2b_period: got %0d and %0d clocks, required 19", t[1] - t[0], t[2] - t[1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    issue(1000, 7);
    drain(40);
    issue(20000, 3);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({busy, out_valid, ovf, dz, q, r} !== 38'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy=%b vld=%b q=%h r=%h in_ready=%b, required 0s and ready",
               busy, out_valid, q, r, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = n_valid;
    repeat (25) @(posedge clk);
    checks++;
    if (n_valid != v0) begin
      errors++;
      $display("FAIL mid_reset_no_valid: got %0d results, required 0", n_valid - v0);
    end
    issue(-123456, 100);
    drain(40);
    checks++;
    if (sb.size() != 0 || n_valid - v0 != 1) begin
      errors++;
      $display("FAIL mid_reset_fresh: got %0d results %0d pending, required 1 and 0", n_valid - v0, sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_closed_loop;
    test_signs;
    test_div_zero;
    test_range;
    test_handshake;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
